// File: rtl/ctrl_pipe_if.sv
// ctrl_pipe_if
//   Bundles every non-clock signal of ctrl_pipe so the datapath (or a bench)
//   connects through one port.
//   Decode side : wb_in[1:0], m_in[2:0], ex_in[3:0], id_rs, id_rt
//   EX feedback : ex_zero, ex_wreg
//   Hazard      : stall, flush_ifid, pcsrc
//   Stage lines : ex_regdst/ex_aluop/ex_alusrc/ex_rs/ex_rt,
//                 mem_branch/mem_memread/mem_memwrite,
//                 wb_regwrite/wb_memtoreg/wb_wreg
//   Forwarding  : forward_a, forward_b (00 regfile, 10 EX/MEM, 01 MEM/WB)
//   There is no valid/ready handshake: every field is sampled on every
//   rising clock edge, and outputs are meaningful in every cycle.
//   modport slave is the control block, modport master the datapath side.
interface ctrl_pipe_if;
    logic [1:0] wb_in;
    logic [2:0] m_in;
    logic [3:0] ex_in;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       ex_zero;
    logic [4:0] ex_wreg;

    logic       stall;
    logic       flush_ifid;
    logic       pcsrc;
    logic       ex_regdst;
    logic       ex_alusrc;
    logic [1:0] ex_aluop;
    logic [4:0] ex_rs;
    logic [4:0] ex_rt;
    logic       mem_branch;
    logic       mem_memread;
    logic       mem_memwrite;
    logic       wb_regwrite;
    logic       wb_memtoreg;
    logic [4:0] wb_wreg;
    logic [1:0] forward_a;
    logic [1:0] forward_b;

    modport slave (
        input  wb_in, m_in, ex_in, id_rs, id_rt, ex_zero, ex_wreg,
        output stall, flush_ifid, pcsrc,
        output ex_regdst, ex_alusrc, ex_aluop, ex_rs, ex_rt,
        output mem_branch, mem_memread, mem_memwrite,
        output wb_regwrite, wb_memtoreg, wb_wreg,
        output forward_a, forward_b
    );

    modport master (
        output wb_in, m_in, ex_in, id_rs, id_rt, ex_zero, ex_wreg,
        input  stall, flush_ifid, pcsrc,
        input  ex_regdst, ex_alusrc, ex_aluop, ex_rs, ex_rt,
        input  mem_branch, mem_memread, mem_memwrite,
        input  wb_regwrite, wb_memtoreg, wb_wreg,
        input  forward_a, forward_b
    );
endinterface

// File: rtl/ctrl_pipe.sv
// ctrl_pipe
//   Carries the decode-stage WB/M/EX control bundles through the ID/EX,
//   EX/MEM and MEM/WB banks of a 5-stage MIPS pipeline, and generates
//   load-use stalls, taken-branch flushes and ALU forwarding selects.
//   Ports:
//     clk   rising-edge clock
//     rst_n asynchronous active-low reset, clears every bank
//     bus   ctrl_pipe_if.slave (decode inputs, EX feedback, all outputs)
module ctrl_pipe (
    input  logic         clk,
    input  logic         rst_n,
    ctrl_pipe_if.slave   bus
);

    // ID/EX bank
    logic [1:0] idex_wb_q,   idex_wb_d;
    logic [2:0] idex_m_q,    idex_m_d;
    logic [3:0] idex_ex_q,   idex_ex_d;
    logic [4:0] idex_rs_q,   idex_rs_d;
    logic [4:0] idex_rt_q,   idex_rt_d;
    // EX/MEM bank
    logic [1:0] exmem_wb_q,   exmem_wb_d;
    logic [2:0] exmem_m_q,    exmem_m_d;
    logic       exmem_zero_q, exmem_zero_d;
    logic [4:0] exmem_wreg_q, exmem_wreg_d;
    // MEM/WB bank
    logic [1:0] memwb_wb_q,   memwb_wb_d;
    logic [4:0] memwb_wreg_q, memwb_wreg_d;

    logic pcsrc;
    logic hazard;
    logic stall;

    // Branch resolves in MEM.
    assign pcsrc  = exmem_m_q[2] & exmem_zero_q;
    // Load in EX whose destination is a source of the instruction in ID.
    // A load into $0 never creates a dependency.
    assign hazard = idex_m_q[1] & (idex_rt_q != 5'd0) &
                    ((idex_rt_q == bus.id_rs) | (idex_rt_q == bus.id_rt));
    // A taken branch discards the ID instruction anyway, so it wins.
    assign stall  = hazard & ~pcsrc;

    always_comb begin
        // Default: every bank advances.
        idex_wb_d    = bus.wb_in;
        idex_m_d     = bus.m_in;
        idex_ex_d    = bus.ex_in;
        idex_rs_d    = bus.id_rs;
        idex_rt_d    = bus.id_rt;
        exmem_wb_d   = idex_wb_q;
        exmem_m_d    = idex_m_q;
        exmem_zero_d = bus.ex_zero;
        exmem_wreg_d = bus.ex_wreg;
        memwb_wb_d   = exmem_wb_q;
        memwb_wreg_d = exmem_wreg_q;

        if (pcsrc) begin
            // Squash the two younger in-flight instructions; the branch
            // itself still retires into MEM/WB.
            idex_wb_d    = '0;
            idex_m_d     = '0;
            idex_ex_d    = '0;
            idex_rs_d    = '0;
            idex_rt_d    = '0;
            exmem_wb_d   = '0;
            exmem_m_d    = '0;
            exmem_zero_d = 1'b0;
            exmem_wreg_d = '0;
        end else if (stall) begin
            // Insert one bubble behind the load; IF/ID holds externally.
            idex_wb_d = '0;
            idex_m_d  = '0;
            idex_ex_d = '0;
            idex_rs_d = '0;
            idex_rt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_wb_q    <= '0;
            idex_m_q     <= '0;
            idex_ex_q    <= '0;
            idex_rs_q    <= '0;
            idex_rt_q    <= '0;
            exmem_wb_q   <= '0;
            exmem_m_q    <= '0;
            exmem_zero_q <= 1'b0;
            exmem_wreg_q <= '0;
            memwb_wb_q   <= '0;
            memwb_wreg_q <= '0;
        end else begin
            idex_wb_q    <= idex_wb_d;
            idex_m_q     <= idex_m_d;
            idex_ex_q    <= idex_ex_d;
            idex_rs_q    <= idex_rs_d;
            idex_rt_q    <= idex_rt_d;
            exmem_wb_q   <= exmem_wb_d;
            exmem_m_q    <= exmem_m_d;
            exmem_zero_q <= exmem_zero_d;
            exmem_wreg_q <= exmem_wreg_d;
            memwb_wb_q   <= memwb_wb_d;
            memwb_wreg_q <= memwb_wreg_d;
        end
    end

    // Forwarding: the younger writer (EX/MEM) takes priority over MEM/WB.
    logic exmem_writes;
    logic memwb_writes;
    assign exmem_writes = exmem_wb_q[1] & (exmem_wreg_q != 5'd0);
    assign memwb_writes = memwb_wb_q[1] & (memwb_wreg_q != 5'd0);

    always_comb begin
        bus.forward_a = 2'b00;
        if (exmem_writes && (exmem_wreg_q == idex_rs_q)) begin
            bus.forward_a = 2'b10;
        end else if (memwb_writes && (memwb_wreg_q == idex_rs_q)) begin
            bus.forward_a = 2'b01;
        end
    end

    always_comb begin
        bus.forward_b = 2'b00;
        if (exmem_writes && (exmem_wreg_q == idex_rt_q)) begin
            bus.forward_b = 2'b10;
        end else if (memwb_writes && (memwb_wreg_q == idex_rt_q)) begin
            bus.forward_b = 2'b01;
        end
    end

    assign bus.stall        = stall;
    assign bus.flush_ifid   = pcsrc;
    assign bus.pcsrc        = pcsrc;
    assign bus.ex_regdst    = idex_ex_q[3];
    assign bus.ex_aluop     = idex_ex_q[2:1];
    assign bus.ex_alusrc    = idex_ex_q[0];
    assign bus.ex_rs        = idex_rs_q;
    assign bus.ex_rt        = idex_rt_q;
    assign bus.mem_branch   = exmem_m_q[2];
    assign bus.mem_memread  = exmem_m_q[1];
    assign bus.mem_memwrite = exmem_m_q[0];
    assign bus.wb_regwrite  = memwb_wb_q[1];
    assign bus.wb_memtoreg  = memwb_wb_q[0];
    assign bus.wb_wreg      = memwb_wreg_q;

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Pipelined control carrier and hazard unit for the 5-stage MIPS datapath. It consumes the WB/M/EX control bundles produced by the decode-stage control unit and carries them through the ID/EX, EX/MEM and MEM/WB stages. It unpacks each bundle into per-stage control lines and tracks destination registers. It also generates load-use stalls, taken-branch flushes and ALU forwarding selects.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- wb_in  in  2  decode bundle: [1] RegWrite, [0] MemtoReg.
- m_in  in  3  decode bundle: [2] Branch, [1] MemRead, [0] MemWrite.
- ex_in  in  4  decode bundle: [3] RegDst, [2:1] ALUOp, [0] ALUSrc.
- id_rs, id_rt  in  5 each  source register fields of the instruction in ID.
- ex_zero  in  1  ALU zero flag of the instruction in EX.
- ex_wreg  in  5  destination register chosen in EX by the external RegDst mux.
- stall  out  1  hold PC and IF/ID this cycle.
- flush_ifid  out  1  clear IF/ID at the next edge.
- pcsrc  out  1  take the branch target.
- ex_regdst, ex_alusrc  out  1 each; ex_aluop  out  2  EX-stage controls.
- ex_rs, ex_rt  out  5 each  EX-stage source registers.
- mem_branch, mem_memread, mem_memwrite  out  1 each  MEM-stage controls.
- wb_regwrite, wb_memtoreg  out  1 each; wb_wreg  out  5  WB-stage controls and destination register.
- forward_a, forward_b  out  2 each  ALU operand select: 00 register file, 10 EX/MEM result, 01 MEM/WB result.

## Operation
- Three register banks:
  - ID/EX holds wb, m, ex, rs and rt.
  - EX/MEM holds wb, m, zero and wreg.
  - MEM/WB holds wb and wreg.
- Stage outputs are direct decodes of their bank. Bundle bits are captured verbatim. Don't-care bits are stored as given, and consumers must ignore them.
- A bubble is all-zero controls. The register fields of a bubble are also zero.
- pcsrc = EX/MEM.Branch & EX/MEM.zero (combinational).
- A hazard exists when ID/EX.MemRead = 1, ID/EX.rt ≠ 0, and ID/EX.rt equals id_rs or id_rt.
- stall = hazard & ~pcsrc. flush_ifid = pcsrc.
- Clock-edge update rules:
  - If pcsrc: ID/EX ← bubble, EX/MEM ← bubble, MEM/WB ← EX/MEM.
  - Else if stall: ID/EX ← bubble; EX/MEM and MEM/WB advance normally.
  - Else: all banks advance. ID/EX ← decode inputs; EX/MEM ← ID/EX plus ex_zero and ex_wreg; MEM/WB ← EX/MEM.
- forward_a (evaluated against ex_rs), in priority order:
  - 10 if EX/MEM.RegWrite and EX/MEM.wreg ≠ 0 and EX/MEM.wreg = ex_rs;
  - else 01 if MEM/WB.RegWrite and MEM/WB.wreg ≠ 0 and MEM/WB.wreg = ex_rs;
  - else 00.
- forward_b uses the same rules against ex_rt.

## Timing
- Reset (rst_n low, asynchronous): every bank cleared, so every output is 0. This includes stall, flush_ifid, pcsrc and the forward selects. The first capture occurs on the first rising edge after rst_n deasserts.
- Latency: a bundle presented in cycle N appears on ex_* in N+1, on mem_* in N+2 and on wb_* in N+3.
- ex_zero and ex_wreg are sampled at the end of the instruction's EX cycle.
- stall, pcsrc, flush_ifid and forward_* are combinational from the current bank state and id_rs/id_rt. They settle within the same cycle.
- A load-use stall lasts exactly one cycle. The bubble clears ID/EX.MemRead, so stall drops in the following cycle unless a new load enters ID/EX.
- A taken branch resolves in MEM and discards the 3 younger instructions:
  - the instructions in ID/EX and EX/MEM are bubbled at the edge;
  - flush_ifid clears the IF-stage instruction externally.
- Flush overrides stall in the same cycle.
- Back-to-back loads into $0 never stall or forward.
- Reset asserted mid-stream clears all in-flight control immediately. No writes or memory operations are asserted after that point.

## Test plan
- Reset: hold rst_n = 0 with nonzero inputs → every output 0. Release, then present an R-type bundle (wb = 10, m = 000, ex = 1100) → ex_regdst = 1 and ex_aluop = 10 one cycle later; wb_regwrite = 1 three cycles later, with wb_wreg = the ex_wreg sampled in EX.
- Load-use: lw with rt = 5 (wb = 11, m = 010, ex = 0001), then an instruction with id_rs = 5 → stall = 1 for exactly one cycle. The next ex_* is a bubble (all 0), then the dependent instruction follows. The same case with rt = 0 → no stall.
- Taken branch: beq (m = 100, ex = 0010) with ex_zero = 1 → pcsrc = 1 and flush_ifid = 1 two cycles after decode; the next edge zeroes ex_* and mem_*. With ex_zero = 0 → no flush.
- Forwarding priority: two R-types writing $7 back-to-back, then an instruction with rs = rt = 7 → forward_a = forward_b = 10. With only the older writer in flight → 01. With the writer's wreg = 0 → 00.
- Stall and flush together: a load-use hazard in ID while a taken branch is in MEM → stall = 0, pcsrc = 1, and ID/EX and EX/MEM bubbled.
- Reset mid-operation: pull rst_n low with a lw in EX/MEM → mem_memread drops to 0 asynchronously before the next edge.
